i2c_master: RTL

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_tick_gen.sv | 36 +++
 rtl/i2c_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: FSM encoding, reference slave address and bit framing constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_ADDR, WRITE_DATA, ACK_DATA, READ_DATA, MACK, STOP
    } state_t;

    localparam logic [6:0] ADDRESS_SLAVE = 7'b1010101;
    localparam int         TICKS_PER_BIT = 4;
    localparam int         DATA_BITS     = 8;
    localparam logic [1:0] LAST_PHASE    = 2'(TICKS_PER_BIT - 1);
    localparam logic [1:0] SAMPLE_PHASE  = 2'(TICKS_PER_BIT - 2);

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider plus 2-bit phase counter; both idle at zero while run is low.
// tick is combinational on the last divider count, so the first tick lands CLK_DIV cycles after run rises.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= '0;
        end else if (!run) begin
            cnt   <= '0;
            phase <= '0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= (phase == LAST_PHASE) ? 2'd0 : phase + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master (write or read), open-drain lines, no clock stretching.
// Full transaction completes 80*CLK_DIV cycles after acceptance; start is ignored while busy or during done.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        sda,
    inout  wire        scl
);

    state_t     state, state_nxt;
    logic       tick, bit_end, sample;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, wdata_q;
    logic       rw_q;
    logic       sda_meta, sda_sync;
    logic       sda_low, scl_low;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (busy),
        .tick  (tick),
        .phase (phase)
    );

    assign bit_end = tick && (phase == LAST_PHASE);
    assign sample  = tick && (phase == SAMPLE_PHASE);

    assign sda = sda_low ? 1'b0 : 1'bz;
    assign scl = scl_low ? 1'b0 : 1'bz;

    always_comb begin
        state_nxt = state;
        sda_low   = 1'b0;
        scl_low   = 1'b0;
        case (state)
            IDLE:       if (start && !done) state_nxt = START;
            START: begin
                sda_low = (phase != 2'd0);
                scl_low = (phase == LAST_PHASE);
                if (bit_end) state_nxt = ADDR;
            end
            ADDR: begin
                sda_low = !shreg[7];
                scl_low = (phase < SAMPLE_PHASE);
                if (bit_end && bit_cnt == 3'd0) state_nxt = ACK_ADDR;
            end
            ACK_ADDR: begin
                scl_low = (phase < SAMPLE_PHASE);
                if (bit_end) state_nxt = ack_error ? STOP : (rw_q ? READ_DATA : WRITE_DATA);
            end
            WRITE_DATA: begin
                sda_low = !shreg[7];
                scl_low = (phase < SAMPLE_PHASE);
                if (bit_end && bit_cnt == 3'd0) state_nxt = ACK_DATA;
            end
            ACK_DATA: begin
                scl_low = (phase < SAMPLE_PHASE);
                if (bit_end) state_nxt = STOP;
            end
            READ_DATA: begin
                scl_low = (phase < SAMPLE_PHASE);
                if (bit_end && bit_cnt == 3'd0) state_nxt = MACK;
            end
            MACK: begin
                scl_low = (phase < SAMPLE_PHASE);
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                sda_low = (phase != LAST_PHASE);
                scl_low = (phase == 2'd0);
                if (bit_end) state_nxt = IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            state    <= state_nxt;
            sda_meta <= sda;
            sda_sync <= sda_meta;
        end
    end

    // Shift register serves address, write byte and read byte in turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (state_nxt == START) begin
                    busy      <= 1'b1;
                    ack_error <= 1'b0;
                    rw_q      <= rw;
                    wdata_q   <= wdata;
                    shreg     <= {addr, rw};
                    bit_cnt   <= 3'(DATA_BITS - 1);
                end
                ADDR, WRITE_DATA: if (bit_end) begin
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt - 3'd1;
                end
                ACK_ADDR: begin
                    if (sample && sda_sync) ack_error <= 1'b1;
                    if (bit_end) begin
                        shreg   <= wdata_q;
                        bit_cnt <= 3'(DATA_BITS - 1);
                    end
                end
                ACK_DATA: if (sample && sda_sync) ack_error <= 1'b1;
                READ_DATA: begin
                    if (sample)  shreg   <= {shreg[6:0], sda_sync};
                    if (bit_end) bit_cnt <= bit_cnt - 3'd1;
                end
                MACK: if (bit_end) rdata <= shreg;
                STOP: if (bit_end) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
